// File: rtl/seg7_scan_drv.sv
// Four-digit multiplexed 7-segment driver for an mm:ss display, with per-frame input snapshot.
// Optional blink mode is compiled in with `define SEG_BLINK_EN.
module seg7_scan_drv #(
    parameter int SCAN_DIV = 50000
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] SEC10,
    input  logic [2:0] SEC6,
    input  logic [3:0] MIN10,
    input  logic [2:0] MIN6,
    input  logic       LZB,
    input  logic       COLON,
`ifdef SEG_BLINK_EN
    input  logic       BLINK,
`endif
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       FRAME
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] pcnt;
    logic [1:0]    idx;
    logic [3:0]    s_sec10;
    logic [2:0]    s_sec6;
    logic [3:0]    s_min10;
    logic [2:0]    s_min6;
    logic          tick;
    logic          snap;
    logic          blank_all;
    logic [6:0]    seg_nxt;

    assign tick = (pcnt == PW'(SCAN_DIV - 1));
    assign snap = tick && (idx == 2'd3);

    function automatic logic [6:0] enc_digit(input logic [3:0] v, input logic [3:0] vmax);
        logic [6:0] s;
        s = 7'h3F;
        if (v <= vmax) begin
            case (v)
                4'd0:    s = 7'h40;
                4'd1:    s = 7'h79;
                4'd2:    s = 7'h24;
                4'd3:    s = 7'h30;
                4'd4:    s = 7'h19;
                4'd5:    s = 7'h12;
                4'd6:    s = 7'h02;
                4'd7:    s = 7'h78;
                4'd8:    s = 7'h00;
                4'd9:    s = 7'h10;
                default: s = 7'h3F;
            endcase
        end
        return s;
    endfunction

    always_comb begin
        seg_nxt = 7'h7F;
        case (idx)
            2'd0: seg_nxt = enc_digit(s_sec10, 4'd9);
            2'd1: seg_nxt = enc_digit({1'b0, s_sec6}, 4'd5);
            2'd2: seg_nxt = enc_digit(s_min10, 4'd9);
            2'd3: seg_nxt = (LZB && (s_min6 == 3'd0)) ? 7'h7F : enc_digit({1'b0, s_min6}, 4'd5);
            default: seg_nxt = 7'h7F;
        endcase
    end

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] fcnt;

    // Counter advances on the same edge that raises FRAME.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fcnt <= '0;
        end else if (snap) begin
            fcnt <= (fcnt == FW'(BLINK_FRAMES - 1)) ? '0 : fcnt + 1'b1;
        end
    end

    assign blank_all = BLINK && (int'(fcnt) >= (BLINK_FRAMES / 2));
`else
    assign blank_all = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pcnt    <= '0;
            idx     <= 2'd0;
            s_sec10 <= 4'd0;
            s_sec6  <= 3'd0;
            s_min10 <= 4'd0;
            s_min6  <= 3'd0;
            AN      <= 4'b1111;
            SEG     <= 7'h7F;
            DP      <= 1'b1;
            FRAME   <= 1'b0;
        end else begin
            pcnt  <= tick ? '0 : pcnt + 1'b1;
            FRAME <= snap;
            if (tick) begin
                idx <= idx + 2'd1;
            end
            // The shadow copy changes only as digit 3 hands over to digit 0.
            if (snap) begin
                s_sec10 <= SEC10;
                s_sec6  <= SEC6;
                s_min10 <= MIN10;
                s_min6  <= MIN6;
            end
            AN  <= ~(4'b0001 << idx);
            SEG <= blank_all ? 7'h7F : seg_nxt;
            DP  <= blank_all ? 1'b1 : !((idx == 2'd2) && COLON);
        end
    end

endmodule
